// File: rtl/arbtst_shared_server.sv
// Two-client round-robin arbiter in front of a single-operation compute unit.
// Serves one request at a time: grant/capture, compute, then return the result with a done pulse.
module arbtst_shared_server #(
    parameter int WIDTH = 4,
    parameter int OP    = 0,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [CNTW-1:0]  served,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sel;
    logic             r_last;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [WIDTH-1:0] r_y0;
    logic [WIDTH-1:0] r_y1;
    logic             r_busy;
    logic [CNTW-1:0]  r_served;

    logic             w_pick1;
    logic [WIDTH-1:0] w_result;

    // Handshake: reqN is a level held with aN/bN until gntN pulses; operands are
    // sampled only at IDLE edges, and a req still high at the next IDLE edge is a new request.
    // On a tie the client that was not served last wins; r_last resets to 1 so client 0 wins first.
    assign w_pick1 = req1 && (!req0 || !r_last);

    always_comb begin
        w_result = r_a + r_b;
        case (OP)
            1:       w_result = r_a - r_b;
            2:       w_result = r_a ^ r_b;
            default: w_result = r_a + r_b;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_y0     <= '0;
            r_y1     <= '0;
            r_busy   <= 1'b0;
            r_served <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_sel   <= w_pick1;
                        r_a     <= w_pick1 ? a1 : a0;
                        r_b     <= w_pick1 ? b1 : b0;
                        r_gnt0  <= !w_pick1;
                        r_gnt1  <= w_pick1;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                    if (r_sel) begin
                        r_y1    <= w_result;
                        r_done1 <= 1'b1;
                    end else begin
                        r_y0    <= w_result;
                        r_done0 <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_last   <= r_sel;
                    r_served <= r_served + CNTW'(1);
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign y0        = r_y0;
    assign y1        = r_y1;
    assign busy      = r_busy;
    assign served    = r_served;
    assign dbg_state = r_state;

endmodule

// File: doc/arbtst_shared_server.md
Name: arbtst_shared_server

Overview:
- Shared compute resource with a built-in two-client round-robin arbiter; sits directly downstream of the arbitration test clients.
- Each client presents operands with a request and holds them until granted.
- The block serves one request at a time: it captures the operands, computes one registered result, and returns it to the granted client with a one-cycle done pulse.
- Used to exercise contention, fairness and result return in the arbiter testbench.

Parameters:
WIDTH, 4, operand/result width in bits
OP, 0, operation: 0 = a+b mod 2^WIDTH, 1 = a-b mod 2^WIDTH, 2 = a^b; any other value behaves as 0
CNTW, 8, width of served-request counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req0  in  1  client 0 request, level, held until gnt0
a0  in  WIDTH  client 0 operand a, valid while req0=1
b0  in  WIDTH  client 0 operand b, valid while req0=1
req1  in  1  client 1 request
a1  in  WIDTH  client 1 operand a
b1  in  WIDTH  client 1 operand b
gnt0  out  1  one-cycle pulse, client 0 operands captured
gnt1  out  1  one-cycle pulse, client 1 operands captured
y0  out  WIDTH  result for client 0, held until next client-0 result
y1  out  WIDTH  result for client 1, held until next client-1 result
done0  out  1  one-cycle pulse, y0 newly valid
done1  out  1  one-cycle pulse, y1 newly valid
busy  out  1  1 whenever state != IDLE
served  out  CNTW  count of completed responses, wraps at 2^CNTW

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset=0 resets immediately, independent of clk).
- Reset values: state=IDLE, gnt0/1=0, done0/1=0, y0/1=0, busy=0, served=0, last=1 (client 0 wins the first tie). Operand registers are cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states and transitions:
  - IDLE: req0/req1 are sampled only at edges where state=IDLE.
  - If no request is present, stay in IDLE.
  - If exactly one request is present, grant that client.
  - If both are present, grant the client != last.
  - On a grant at edge t0: capture a_k/b_k, record k, set gnt_k=1, go to EXEC.
  - EXEC (cycle after t0, gnt_k high): at edge t1, register f(a,b) per OP truncated to WIDTH, clear gnt, go to RESP.
  - RESP (cycle after t1): y_k=result and done_k=1. At edge t2: done_k=0, last=k, served+=1 (wraps), go to IDLE.
- Latency and throughput:
  - gnt is high one cycle after the sampling edge.
  - done is high two cycles after the sampling edge; it immediately follows the gnt cycle plus one EXEC-to-RESP cycle.
  - One request is served per 3 cycles at best (IDLE, EXEC, RESP).
- Client rule: deassert req no later than the RESP cycle. A req still high at the next IDLE edge is treated as a new request.
- Operands are ignored outside IDLE sampling edges.
- Only one gnt and one done are ever high at a time. The y of the non-served client is unchanged.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1… starting with 0 after reset.
- Reset mid-operation: the in-flight request is dropped, no done is issued, and all registers return to reset values. The next request is served normally.
- Arithmetic: subtraction wraps (2-5 = 13 for WIDTH=4). No carry or borrow output.

Test Plan:
1. Assert reset=0 mid-cycle with requests active -> all outputs 0 immediately and state IDLE; after release with no requests, busy stays 0.
2. OP=0, req0=1, a0=3, b0=5 -> gnt0 pulse one cycle after sampling edge; done0 pulse two cycles after; y0=8; y1 stays 0; served=1.
3. OP=0, req1, a1=9, b1=9 -> y1=2 (wrap); OP=1 build, req0, a0=2, b0=5 -> y0=13.
4. req0 and req1 held high continuously after reset (a0=1,b0=1,a1=2,b1=2) -> grant order 0,1,0,1; y0=2, y1=4; done pulses spaced 3 cycles apart; served increments per done.
5. Drive reset=0 during EXEC of a client-1 request -> no done1, y1=0; after release, req0 (4+4) served normally with y0=8.
6. CNTW=2 with 5 back-to-back requests -> served sequence 1,2,3,0,1.
